// File: rtl/sine_period_meter.sv
// Recovers the period of an 8-bit unsigned sine stream by timing midscale rising
// crossings with hysteresis, averaging 2**AVG_LOG2 periods per reported result.
module sine_period_meter #(
   parameter logic [7:0] MID      = 8'h80,
   parameter logic [7:0] HYST     = 8'd8,
   parameter int         CNT_W    = 16,
   parameter int         AVG_LOG2 = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sample_valid_i,
   input  logic [7:0]       sample_i,
   output logic [CNT_W-1:0] period_o,
   output logic             period_valid_o,
   output logic             locked_o,
   output logic             timeout_o
);

   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int NPER_W = AVG_LOG2 + 1;
   localparam logic [7:0] ARM_LVL = MID - HYST;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((2 ** AVG_LOG2) - 1);

   typedef enum logic {IDLE, MEAS} state_t;

   state_t              state_reg, state_next;
   logic                armed_reg, armed_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [ACC_W-1:0]    acc_reg, acc_next;
   logic [NPER_W-1:0]   nper_reg, nper_next;
   logic [CNT_W-1:0]    period_reg, period_next;
   logic                valid_reg, valid_next;
   logic                locked_reg, locked_next;
   logic                timeout_reg, timeout_next;

   logic                arm_hit;
   logic                trig;
   logic [CNT_W-1:0]    cnt_inc;
   logic [ACC_W-1:0]    acc_sum;

   // Arming takes priority over triggering on the same sample.
   assign arm_hit = sample_valid_i && (sample_i <= ARM_LVL);
   assign trig    = sample_valid_i && armed_reg && (sample_i >= MID) && !arm_hit;
   assign cnt_inc = cnt_reg + CNT_W'(1);
   assign acc_sum = acc_reg + ACC_W'(cnt_reg) + ACC_W'(1);

   always_comb begin
      state_next   = state_reg;
      armed_next   = armed_reg;
      cnt_next     = cnt_reg;
      acc_next     = acc_reg;
      nper_next    = nper_reg;
      period_next  = period_reg;
      locked_next  = locked_reg;
      valid_next   = 1'b0;
      timeout_next = 1'b0;

      if (arm_hit) begin
         armed_next = 1'b1;
      end else if (trig) begin
         armed_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (trig) begin
               cnt_next   = '0;
               state_next = MEAS;
            end
         end
         MEAS: begin
            if (trig) begin
               cnt_next = '0;
               if (nper_reg == NPER_LAST) begin
                  period_next = CNT_W'(acc_sum >> AVG_LOG2);
                  valid_next  = 1'b1;
                  locked_next = 1'b1;
                  acc_next    = '0;
                  nper_next   = '0;
               end else begin
                  acc_next  = acc_sum;
                  nper_next = nper_reg + NPER_W'(1);
               end
            end else if (sample_valid_i) begin
               // Stopping one short of wrap keeps every measured period representable.
               if (cnt_inc == CNT_MAX) begin
                  timeout_next = 1'b1;
                  state_next   = IDLE;
                  cnt_next     = '0;
                  acc_next     = '0;
                  nper_next    = '0;
                  armed_next   = 1'b0;
                  locked_next  = 1'b0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         armed_reg   <= 1'b0;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         nper_reg    <= '0;
         period_reg  <= '0;
         valid_reg   <= 1'b0;
         locked_reg  <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         armed_reg   <= armed_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         nper_reg    <= nper_next;
         period_reg  <= period_next;
         valid_reg   <= valid_next;
         locked_reg  <= locked_next;
         timeout_reg <= timeout_next;
      end
   end

   assign period_o       = period_reg;
   assign period_valid_o = valid_reg;
   assign locked_o       = locked_reg;
   assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_sine_period_meter.sv
// Scoreboard bench for sine_period_meter: a 16-bit counter instance for the averaging
// tests and an 8-bit counter instance for the timeout tests.
module tb_sine_period_meter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, rst8, sample_valid;
   logic [7:0]  sample;
   logic [15:0] period16;
   logic        valid16, locked16, tmo16;
   logic [7:0]  period8;
   logic        valid8, locked8, tmo8;

   sine_period_meter #(.CNT_W(16)) dut16 (
      .clk_i(clk), .rst_i(rst16), .sample_valid_i(sample_valid), .sample_i(sample),
      .period_o(period16), .period_valid_o(valid16), .locked_o(locked16), .timeout_o(tmo16)
   );

   sine_period_meter #(.CNT_W(8)) dut8 (
      .clk_i(clk), .rst_i(rst8), .sample_valid_i(sample_valid), .sample_i(sample),
      .period_o(period8), .period_valid_o(valid8), .locked_o(locked8), .timeout_o(tmo8)
   );

   typedef struct packed {
      logic        tmo;
      logic [15:0] period;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   tmo_seen8 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0d required %0d", name, act, req);
   endtask

   task automatic score(input string tag, input exp_t e, input logic t,
                        input logic [15:0] p, input logic l);
      $display("%s event: timeout=%0d period=%0d locked=%0d", tag, t, p, l);
      check({tag, " kind"}, 32'(t), 32'(e.tmo));
      check({tag, " period"}, 32'(p), 32'(e.period));
      check({tag, " locked"}, 32'(l), 32'(!e.tmo));
   endtask

   // Monitor: every output event must match the head of its queue.
   always @(negedge clk) begin
      exp_t e;
      if (valid16 || tmo16) begin
         if (q16.size() == 0) begin
            total_cnt++;
            $display("FAIL dut16 unexpected event: got valid=%0d timeout=%0d required none",
                     valid16, tmo16);
         end else begin
            e = q16.pop_front();
            score("dut16", e, tmo16, period16, locked16);
         end
      end
      if (valid8 || tmo8) begin
         if (tmo8) tmo_seen8++;
         if (q8.size() == 0) begin
            total_cnt++;
            $display("FAIL dut8 unexpected event: got valid=%0d timeout=%0d required none",
                     valid8, tmo8);
         end else begin
            e = q8.pop_front();
            score("dut8", e, tmo8, {8'h00, period8}, locked8);
         end
      end
   end

   function automatic logic [7:0] lut(input int ph);
      real v;
      v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(ph % 256) / 256.0);
      return 8'($rtoi(v + 0.5));
   endfunction

   task automatic step(input logic v, input logic [7:0] s);
      sample_valid = v;
      sample = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   // Invalid cycles carry the inverted sample, which would arm or trigger if accepted.
   task automatic sine(input int start, input int stride, input int n, input bit toggle);
      int ph = start;
      for (int i = 0; i < n; i++) begin
         step(1'b1, lut(ph));
         if (toggle) step(1'b0, ~lut(ph));
         ph += stride;
      end
   endtask

   task automatic pulse_rst16();
      rst16 = 1'b1;
      step(1'b0, 8'h00);
      rst16 = 1'b0;
   endtask

   initial begin
      rst16 = 1'b1;
      rst8 = 1'b1;
      sample_valid = 1'b0;
      sample = 8'h00;
      idle(3);
      check("reset period16", 32'(period16), 0);
      check("reset valid16", 32'(valid16), 0);
      check("reset locked16", 32'(locked16), 0);
      check("reset timeout16", 32'(tmo16), 0);
      check("reset period8", 32'(period8), 0);
      check("reset locked8", 32'(locked8), 0);
      rst16 = 1'b0;

      // Test 1: step-1 sine, first trigger at phase 0 then four periods.
      q16.push_back('{tmo: 1'b0, period: 16'd256});
      sine(128, 1, 1153, 1'b0);
      idle(4);
      check("t1 locked", 32'(locked16), 1);

      // Test 2: step-2 sine, two consecutive results.
      pulse_rst16();
      check("t2 locked after reset", 32'(locked16), 0);
      q16.push_back('{tmo: 1'b0, period: 16'd128});
      q16.push_back('{tmo: 1'b0, period: 16'd128});
      sine(128, 2, 1089, 1'b0);
      idle(4);

      // Test 3: valid toggling, invalid cycles must not count.
      pulse_rst16();
      q16.push_back('{tmo: 1'b0, period: 16'd256});
      sine(128, 1, 1153, 1'b1);
      idle(4);
      check("t3 period", 32'(period16), 256);

      // Test 6: reset during the 3rd period discards the partial average.
      sine(128, 1, 700, 1'b0);
      rst16 = 1'b1;
      step(1'b1, 8'h80);
      rst16 = 1'b0;
      check("t6 reset period", 32'(period16), 0);
      check("t6 reset locked", 32'(locked16), 0);
      check("t6 reset valid", 32'(valid16), 0);
      q16.push_back('{tmo: 1'b0, period: 16'd256});
      sine(128, 1, 1153, 1'b0);
      idle(4);
      check("t6 period", 32'(period16), 256);
      rst16 = 1'b1;

      // Test 4: CNT_W=8, lock then hold midscale until timeout.
      rst8 = 1'b0;
      q8.push_back('{tmo: 1'b0, period: 16'd128});
      sine(128, 2, 577, 1'b0);
      q8.push_back('{tmo: 1'b1, period: 16'd128});
      for (int i = 0; i < 254; i++) step(1'b1, 8'h80);
      @(negedge clk); #1;
      check("t4 no early timeout", 32'(tmo_seen8), 0);
      check("t4 still locked", 32'(locked8), 1);
      step(1'b1, 8'h80);
      @(negedge clk); #1;
      check("t4 timeout seen", 32'(tmo_seen8), 1);
      check("t4 unlocked", 32'(locked8), 0);
      idle(3);
      check("t4 single pulse", 32'(tmo_seen8), 1);
      check("t4 period held", 32'(period8), 128);

      // Test 5: midscale noise inside the hysteresis band after lock.
      q8.push_back('{tmo: 1'b0, period: 16'd128});
      sine(128, 2, 577, 1'b0);
      q8.push_back('{tmo: 1'b1, period: 16'd128});
      for (int i = 0; i < 254; i++) step(1'b1, (i % 2 == 0) ? 8'h7C : 8'h84);
      @(negedge clk); #1;
      check("t5 no early timeout", 32'(tmo_seen8), 1);
      step(1'b1, 8'h7C);
      @(negedge clk); #1;
      check("t5 timeout seen", 32'(tmo_seen8), 2);
      check("t5 period held", 32'(period8), 128);

      idle(5);
      check("dut16 pending results", 32'(q16.size()), 0);
      check("dut8 pending results", 32'(q8.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
